// File: rtl/aes_pkg.sv
// ---------------------------------------------------------------------------
// aes_pkg
// Shared AES definitions: scheduler FSM states, requester identifiers and
// the job lengths (in bytes) of the two sbox clients.
// ---------------------------------------------------------------------------
package aes_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } sched_state_e;

    typedef enum logic {
        REQ_SB = 1'b0,
        REQ_KE = 1'b1
    } req_id_e;

    localparam int SB_BYTES = 16;
    localparam int KE_BYTES = 4;

endpackage

// File: rtl/sbox_sync.sv
// ---------------------------------------------------------------------------
// sbox_sync
// Synchronous AES forward S-box with a configurable read latency.
// Ports:
//   clk   - rising-edge clock
//   reset - asynchronous active-high reset (clears the output pipeline)
//   addr  - byte to substitute, sampled every cycle
//   data  - S(addr) presented LAT cycles earlier
// ---------------------------------------------------------------------------
module sbox_sync #(
    parameter int LAT = 1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] addr,
    output logic [7:0] data
);

    // Entry 0 sits in the most significant byte, entry 255 in the least.
    localparam logic [2047:0] SBOX_TABLE = {
        128'h637c777bf26b6fc53001672bfed7ab76,
        128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115,
        128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84,
        128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8,
        128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973,
        128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479,
        128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
        128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df,
        128'h8ca1890dbfe6426841992d0fb054bb16
    };

    function automatic logic [7:0] sbox_lookup(input logic [7:0] a);
        return SBOX_TABLE[{8'd255 - a, 3'b000} +: 8];
    endfunction

    logic [7:0] pipe_d [LAT];
    logic [7:0] pipe_q [LAT];

    // Lookup into the first stage, then shift through the remaining stages.
    always_comb begin
        pipe_d[0] = sbox_lookup(addr);
        for (int i = 1; i < LAT; i++) begin
            pipe_d[i] = pipe_q[i - 1];
        end
    end

    // Output pipeline registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < LAT; i++) begin
                pipe_q[i] <= 8'h00;
            end
        end else begin
            for (int i = 0; i < LAT; i++) begin
                pipe_q[i] <= pipe_d[i];
            end
        end
    end

    assign data = pipe_q[LAT - 1];

endmodule

// File: rtl/aes_sbox_scheduler.sv
// ---------------------------------------------------------------------------
// aes_sbox_scheduler
// Shares one synchronous S-box between a SubBytes client (16 bytes) and a
// key-expansion SubWord client (4 bytes). One byte is issued per cycle; ties
// in IDLE are broken round-robin, starting with ke after reset.
// Ports:
//   clk, reset        - clock, asynchronous active-high reset
//   sb_req / sb_in    - SubBytes request (level) and 128-bit state
//   sb_done / sb_out  - one-cycle completion pulse and held result
//   ke_req / ke_in    - SubWord request (level) and 32-bit word
//   ke_done / ke_out  - one-cycle completion pulse and held result
// ---------------------------------------------------------------------------
module aes_sbox_scheduler
    import aes_pkg::*;
#(
    parameter int SBOX_LAT = 1
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         sb_req,
    input  logic [127:0] sb_in,
    output logic         sb_done,
    output logic [127:0] sb_out,
    input  logic         ke_req,
    input  logic [31:0]  ke_in,
    output logic         ke_done,
    output logic [31:0]  ke_out
);

    sched_state_e  state_q, state_d;
    req_id_e       sel_q, sel_d;
    req_id_e       last_q, last_d;
    req_id_e       grant_s;
    logic          accept_s;
    logic          issuing_s;
    logic [3:0]    last_idx_s;
    logic [127:0]  job_q, job_d;
    logic [127:0]  res_q, res_d;
    logic [3:0]    iss_k_q, iss_k_d;
    logic [3:0]    cap_k_q, cap_k_d;
    logic [SBOX_LAT-1:0] vld_q, vld_d;
    logic          sb_done_q, sb_done_d;
    logic          ke_done_q, ke_done_d;
    logic [127:0]  sb_out_q, sb_out_d;
    logic [31:0]   ke_out_q, ke_out_d;
    logic [7:0]    sbox_addr_s;
    logic [7:0]    sbox_data_s;

    // The byte being issued is selected straight from the latched job.
    assign sbox_addr_s = job_q[{iss_k_q, 3'b000} +: 8];

    sbox_sync #(
        .LAT (SBOX_LAT)
    ) u_sbox (
        .clk   (clk),
        .reset (reset),
        .addr  (sbox_addr_s),
        .data  (sbox_data_s)
    );

    // Valid tag travels alongside the sbox pipeline so capture lags issue by SBOX_LAT.
    always_comb begin
        vld_d[0] = issuing_s;
        for (int i = 1; i < SBOX_LAT; i++) begin
            vld_d[i] = vld_q[i - 1];
        end
    end

    // Next-state, arbitration, capture and output-update logic.
    always_comb begin
        state_d    = state_q;
        sel_d      = sel_q;
        last_d     = last_q;
        job_d      = job_q;
        res_d      = res_q;
        iss_k_d    = iss_k_q;
        cap_k_d    = cap_k_q;
        sb_out_d   = sb_out_q;
        ke_out_d   = ke_out_q;
        sb_done_d  = 1'b0;
        ke_done_d  = 1'b0;
        issuing_s  = 1'b0;
        accept_s   = 1'b0;
        grant_s    = REQ_SB;

        if (sel_q == REQ_SB) begin
            last_idx_s = 4'(SB_BYTES - 1);
        end else begin
            last_idx_s = 4'(KE_BYTES - 1);
        end

        if (vld_q[SBOX_LAT-1]) begin
            res_d[{cap_k_q, 3'b000} +: 8] = sbox_data_s;
            cap_k_d = cap_k_q + 4'd1;
        end else begin
            cap_k_d = cap_k_q;
        end

        case (state_q)
            ST_IDLE: begin
                // Round-robin only matters on a tie: serve whoever was not served last.
                if (sb_req && ke_req) begin
                    accept_s = 1'b1;
                    if (last_q == REQ_SB) begin
                        grant_s = REQ_KE;
                    end else begin
                        grant_s = REQ_SB;
                    end
                end else if (sb_req) begin
                    accept_s = 1'b1;
                    grant_s  = REQ_SB;
                end else if (ke_req) begin
                    accept_s = 1'b1;
                    grant_s  = REQ_KE;
                end else begin
                    accept_s = 1'b0;
                end

                if (accept_s) begin
                    sel_d   = grant_s;
                    last_d  = grant_s;
                    iss_k_d = 4'd0;
                    cap_k_d = 4'd0;
                    res_d   = 128'h0;
                    state_d = ST_ISSUE;
                    if (grant_s == REQ_SB) begin
                        job_d = sb_in;
                    end else begin
                        job_d = {96'h0, ke_in};
                    end
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_ISSUE: begin
                issuing_s = 1'b1;
                if (iss_k_q == last_idx_s) begin
                    state_d = ST_DRAIN;
                end else begin
                    iss_k_d = iss_k_q + 4'd1;
                end
            end
            ST_DRAIN: begin
                // res_d already holds the final byte when the last capture lands.
                if (vld_q[SBOX_LAT-1] && (cap_k_q == last_idx_s)) begin
                    state_d = ST_DONE;
                    if (sel_q == REQ_SB) begin
                        sb_out_d  = res_d;
                        sb_done_d = 1'b1;
                    end else begin
                        ke_out_d  = res_d[31:0];
                        ke_done_d = 1'b1;
                    end
                end else begin
                    state_d = ST_DRAIN;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and datapath registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= ST_IDLE;
            sel_q     <= REQ_SB;
            last_q    <= REQ_SB;
            job_q     <= 128'h0;
            res_q     <= 128'h0;
            iss_k_q   <= 4'd0;
            cap_k_q   <= 4'd0;
            vld_q     <= '0;
            sb_done_q <= 1'b0;
            ke_done_q <= 1'b0;
            sb_out_q  <= 128'h0;
            ke_out_q  <= 32'h0;
        end else begin
            state_q   <= state_d;
            sel_q     <= sel_d;
            last_q    <= last_d;
            job_q     <= job_d;
            res_q     <= res_d;
            iss_k_q   <= iss_k_d;
            cap_k_q   <= cap_k_d;
            vld_q     <= vld_d;
            sb_done_q <= sb_done_d;
            ke_done_q <= ke_done_d;
            sb_out_q  <= sb_out_d;
            ke_out_q  <= ke_out_d;
        end
    end

    assign sb_done = sb_done_q;
    assign ke_done = ke_done_q;
    assign sb_out  = sb_out_q;
    assign ke_out  = ke_out_q;

endmodule

// File: tb/tb_aes_sbox_scheduler.sv
// ---------------------------------------------------------------------------
// tb_aes_sbox_scheduler
// Directed bench for aes_sbox_scheduler (SBOX_LAT = 1) with hand-computed
// S-box results and cycle-accurate completion checks.
// ---------------------------------------------------------------------------
module tb_aes_sbox_scheduler;

    logic         clk;
    logic         reset;
    logic         sb_req;
    logic [127:0] sb_in;
    logic         sb_done;
    logic [127:0] sb_out;
    logic         ke_req;
    logic [31:0]  ke_in;
    logic         ke_done;
    logic [31:0]  ke_out;

    int n_cmp = 0;
    int n_err = 0;
    int cyc   = 0;

    localparam logic [127:0] SB_ZERO_OUT = {16{8'h63}};
    localparam logic [127:0] SB_SEQ_IN   = 128'h0f0e0d0c0b0a09080706050403020100;
    localparam logic [127:0] SB_SEQ_OUT  = 128'h76abd7fe2b670130c56f6bf27b777c63;
    localparam logic [127:0] SB_FF_OUT   = {16{8'h16}};

    aes_sbox_scheduler #(.SBOX_LAT(1)) dut (
        .clk     (clk),
        .reset   (reset),
        .sb_req  (sb_req),
        .sb_in   (sb_in),
        .sb_done (sb_done),
        .sb_out  (sb_out),
        .ke_req  (ke_req),
        .ke_in   (ke_in),
        .ke_done (ke_done),
        .ke_out  (ke_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Cycle index: value seen during a cycle equals the number of edges so far.
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check_eq(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h", tag, obs, exp);
        end
    endtask

    // The two done pulses must never coincide.
    always @(negedge clk) begin
        if (sb_done || ke_done) begin
            check_eq("done_exclusive", {127'h0, sb_done & ke_done}, 128'h0);
        end
    end

    // Issue one job from IDLE (called at a negedge), return done latency in cycles.
    task automatic run_job(input logic is_ke, input logic [127:0] din, input logic flip,
                           output int lat);
        int t;
        lat = -1;
        if (is_ke) begin
            ke_in  = din[31:0];
            ke_req = 1'b1;
        end else begin
            sb_in  = din;
            sb_req = 1'b1;
        end
        t = cyc;
        @(negedge clk);
        sb_req = 1'b0;
        ke_req = 1'b0;
        if (flip) begin
            sb_in = ~sb_in;
            ke_in = ~ke_in;
        end
        for (int n = 0; n < 40; n++) begin
            if ((is_ke && ke_done) || (!is_ke && sb_done)) begin
                lat = cyc - t;
                break;
            end
            @(negedge clk);
        end
        @(negedge clk);
    endtask

    task automatic pulse_reset();
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        int lat, t, t2, ke_at, sb_at, first_at, n_sb;
        int d [3];
        logic winner_ke;

        reset  = 1'b1;
        sb_req = 1'b0;
        ke_req = 1'b0;
        sb_in  = 128'h0;
        ke_in  = 32'h0;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);

        check_eq("rst_sb_done", {127'h0, sb_done}, 128'h0);
        check_eq("rst_ke_done", {127'h0, ke_done}, 128'h0);
        check_eq("rst_sb_out", sb_out, 128'h0);
        check_eq("rst_ke_out", {96'h0, ke_out}, 128'h0);

        // All-zero state through SubBytes.
        run_job(1'b0, 128'h0, 1'b0, lat);
        check_eq("sb_zero_lat", lat, 18);
        check_eq("sb_zero_out", sb_out, SB_ZERO_OUT);

        // SubWord vector; the SubBytes result must survive the ke job.
        run_job(1'b1, {96'h0, 32'h09cf4f3c}, 1'b0, lat);
        check_eq("ke_vec_lat", lat, 6);
        check_eq("ke_vec_out", {96'h0, ke_out}, {96'h0, 32'h018a84eb});
        check_eq("sb_out_kept", sb_out, SB_ZERO_OUT);

        // Inputs inverted during ISSUE must not leak into the result.
        run_job(1'b0, SB_SEQ_IN, 1'b1, lat);
        check_eq("sb_flip_lat", lat, 18);
        check_eq("sb_flip_out", sb_out, SB_SEQ_OUT);
        check_eq("ke_out_kept", {96'h0, ke_out}, {96'h0, 32'h018a84eb});

        run_job(1'b1, {96'h0, 32'h00000000}, 1'b0, lat);
        check_eq("ke_zero_out", {96'h0, ke_out}, {96'h0, 32'h63636363});
        run_job(1'b0, {128{1'b1}}, 1'b0, lat);
        check_eq("sb_ff_out", sb_out, SB_FF_OUT);

        // Tie right after reset: ke first, then sb, then ke again.
        pulse_reset();
        sb_req = 1'b1;
        ke_req = 1'b1;
        sb_in  = 128'h0;
        ke_in  = 32'h09cf4f3c;
        t = cyc;
        @(negedge clk);
        ke_req = 1'b0;
        ke_at = -1;
        sb_at = -1;
        for (int n = 0; n < 60; n++) begin
            if (ke_done && ke_at < 0) ke_at = cyc;
            if (sb_done) begin
                sb_at = cyc;
                break;
            end
            @(negedge clk);
        end
        check_eq("tie1_ke_at", ke_at - t, 6);
        check_eq("tie1_sb_at", sb_at - t, 25);
        ke_req = 1'b1;
        t2 = cyc + 1;
        @(negedge clk);
        @(negedge clk);
        sb_req = 1'b0;
        ke_req = 1'b0;
        first_at  = -1;
        winner_ke = 1'b0;
        for (int n = 0; n < 40; n++) begin
            if (sb_done || ke_done) begin
                first_at  = cyc;
                winner_ke = ke_done;
                break;
            end
            @(negedge clk);
        end
        check_eq("tie2_winner_ke", {127'h0, winner_ke}, 128'h1);
        check_eq("tie2_at", first_at - t2, 6);
        @(negedge clk);

        // Reset in cycle 8 of a SubBytes job aborts it silently.
        sb_in  = 128'h0;
        sb_req = 1'b1;
        t = cyc;
        @(negedge clk);
        sb_req = 1'b0;
        while (cyc < t + 8) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        n_sb = 0;
        for (int n = 0; n < 30; n++) begin
            @(negedge clk);
            if (sb_done) n_sb++;
        end
        check_eq("abort_no_done", n_sb, 0);
        check_eq("abort_sb_out", sb_out, 128'h0);
        check_eq("abort_ke_out", {96'h0, ke_out}, 128'h0);
        run_job(1'b1, {96'h0, 32'h09cf4f3c}, 1'b0, lat);
        check_eq("post_rst_ke_lat", lat, 6);
        check_eq("post_rst_ke_out", {96'h0, ke_out}, {96'h0, 32'h018a84eb});

        // sb_req held high: back-to-back jobs 19 cycles apart.
        sb_in  = SB_SEQ_IN;
        sb_req = 1'b1;
        d[0] = -1;
        d[1] = -1;
        d[2] = -1;
        n_sb = 0;
        for (int n = 0; n < 100; n++) begin
            @(negedge clk);
            if (sb_done) begin
                d[n_sb] = cyc;
                n_sb++;
                if (n_sb == 3) begin
                    sb_req = 1'b0;
                    break;
                end
            end
        end
        check_eq("hold_pulses", n_sb, 3);
        check_eq("hold_gap1", d[1] - d[0], 19);
        check_eq("hold_gap2", d[2] - d[1], 19);
        check_eq("hold_out", sb_out, SB_SEQ_OUT);
        repeat (25) @(negedge clk);
        check_eq("hold_stopped", {127'h0, sb_done}, 128'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/aes_sbox_scheduler.md
AES_SBOX_SCHEDULER -- requirements
Module: aes_sbox_scheduler

Interface
REQ-001 SHALL have parameter SBOX_LAT, default 1, meaning sbox read latency in cycles, from address presented to result valid.
REQ-002 SHALL have port clk  input  1  single system clock; all state on its rising edge.
REQ-003 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-004 SHALL have port sb_req  input  1  sub_bytes job request, level.
REQ-005 SHALL have port sb_in  input  128  sub_bytes state; byte i = sb_in[8i+7:8i].
REQ-006 SHALL have port sb_done  output  1  one-cycle pulse: sb_out valid.
REQ-007 SHALL have port sb_out  output  128  substituted state; byte i corresponds to sb_in byte i.
REQ-008 SHALL have port ke_req  input  1  key-expansion SubWord request, level.
REQ-009 SHALL have port ke_in  input  32  key word; byte i = ke_in[8i+7:8i].
REQ-010 SHALL have port ke_done  output  1  one-cycle pulse: ke_out valid.
REQ-011 SHALL have port ke_out  output  32  SubWord(ke_in), byte-positional.

Function
REQ-012 SHALL share one synchronous sbox between both requesters, one byte issued per cycle.
REQ-013 FSM states SHALL be IDLE, ISSUE, DRAIN, DONE; reset state SHALL be IDLE.
REQ-014 IDLE: a pending request SHALL be accepted; the accepted input SHALL be registered and the block SHALL move to ISSUE; with no request it SHALL stay in IDLE.
REQ-015 Job length N SHALL be 16 for sub_bytes and 4 for key expansion.
REQ-016 ISSUE: byte index k SHALL run 0..N-1, one per cycle; after k=N-1 issues, the block SHALL go to DRAIN.
REQ-017 Result capture index SHALL lag the issue index by exactly SBOX_LAT cycles.
REQ-018 DRAIN: the block SHALL remain until the last byte is captured, then go to DONE.
REQ-019 DONE: the winner's done SHALL pulse for exactly one cycle, then the block SHALL return to IDLE.
REQ-020 For accept cycle t, done SHALL assert in cycle t+N+SBOX_LAT+1: t+18 for sb and t+6 for ke at SBOX_LAT=1.
REQ-021 sb_out/ke_out SHALL hold their value from done until that requester's next done; a new job SHALL NOT corrupt the other requester's output.
REQ-022 Requests SHALL be sampled only in IDLE; req and input changes during ISSUE/DRAIN/DONE SHALL be ignored.
REQ-023 A req still high in IDLE after its done SHALL be accepted as a new job.
REQ-024 Both requests pending in IDLE SHALL be granted to the requester not granted last (round-robin).
REQ-025 The last-grant bit SHALL reset to "sb", so the first tie grants ke.
REQ-026 sb_done and ke_done SHALL never be high in the same cycle.

Reset
REQ-027 Reset SHALL asynchronously force: state IDLE, counters 0, last-grant sb, sb_done=0, ke_done=0, sb_out=0, ke_out=0.
REQ-028 Reset mid-job SHALL abort the job with no done pulse; after reset release, the first request SHALL be accepted normally.

Structure
REQ-029 A shared aes package SHALL hold the FSM state enum, the requester-id enum, and constants SB_BYTES=16 and KE_BYTES=4.
REQ-030 The block SHALL instantiate exactly one sub-module, the team's existing sbox_sync.
REQ-031 The implementation SHALL contain no second sbox instance.

Verification
REQ-032 sb_in=all 0x00, sb_req at t -> sb_done at t+18, sb_out=all 0x63.
REQ-033 ke_in=0x09cf4f3c, ke_req at t -> ke_done at t+6, ke_out=0x018a84eb.
REQ-034 sb_req and ke_req both high after reset -> ke served first; sb accepted the cycle after IDLE returns; next tie goes to ke.
REQ-035 Bench flips sb_in during ISSUE -> sb_out reflects only the value captured at accept.
REQ-036 Reset asserted at cycle 8 of an sb job -> no sb_done, outputs 0; a ke job afterwards completes at t+6.
REQ-037 sb_req held high for three jobs -> three sb_done pulses, each spaced 19 cycles apart.
